// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter
//   Shares the single RAM port between the instruction and data cache ports
//   of CPUS cores. One transfer is in flight at a time. Arbitration scans the
//   cores round-robin from rr, and a data request beats an instruction request
//   within the chosen core. A watchdog aborts a grant that never sees ACCESS.
//
// Ports
//   CLK, nRST            clock; synchronous active-low reset
//   iREN/dREN/dWEN       per-core request strobes (dREN&dWEN counts as a write)
//   iaddr/daddr/dstore   per-core address / write data
//   iwait/dwait          per-core "not done" flags, low for one cycle on ack
//   iload/dload          per-core read data, zero unless the wait bit is low
//   ramaddr/ramstore     RAM address / write data (driven only during GRANT)
//   ramREN/ramWEN        RAM strobes (driven only during GRANT)
//   ramload/ramstate     RAM read data / status (FREE BUSY ACCESS ERROR)
//   timeout              sticky watchdog-abort flag, cleared only by reset
//
// state | meaning
// IDLE  | no strobes; pick a winner and latch it as owner
// GRANT | strobes follow the owner's live inputs until ACCESS, drop or watchdog
// DONE  | one-cycle bubble; rr moves past the owner
module ram_bus_arbiter #(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  output logic                  ramREN,
  output logic                  ramWEN,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic                  timeout
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int SW = CW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_MAX   = '1;
  localparam logic [CW-1:0] CORE_LAST  = CW'(CPUS - 1);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] rr;
  logic [CW-1:0] owner_core;
  logic          owner_data;
  logic          owner_write;
  logic [WW-1:0] wdog;

  logic          any_req;
  logic [CW-1:0] win_core;
  logic          win_data;
  logic          win_write;
  logic [SW-1:0] scan_sum;
  logic [CW-1:0] scan_idx;
  logic          own_req;
  logic          ack;

  // Round-robin scan starting at rr; the first core with any request wins.
  always_comb begin
    any_req   = 1'b0;
    win_core  = '0;
    win_data  = 1'b0;
    win_write = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < CPUS; k++) begin
      scan_sum = {1'b0, rr} + SW'(k);
      if (scan_sum >= SW'(CPUS)) scan_sum = scan_sum - SW'(CPUS);
      scan_idx = scan_sum[CW-1:0];
      if (!any_req && (iREN[scan_idx] || dREN[scan_idx] || dWEN[scan_idx])) begin
        any_req   = 1'b1;
        win_core  = scan_idx;
        win_data  = dREN[scan_idx] | dWEN[scan_idx];
        win_write = dWEN[scan_idx];
      end
    end
  end

  // A data owner stays alive while either data strobe is up.
  always_comb begin
    own_req = owner_data ? (dREN[owner_core] | dWEN[owner_core]) : iREN[owner_core];
    ack     = (state == GRANT) && (ramstate == RAM_ACCESS);
  end

  // Bus and ack outputs are decoded from registered state so that the RAM
  // sees strobes in the cycle after the pick and an ACCESS acks the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (state == GRANT) begin
      ramREN   = ~owner_write;
      ramWEN   = owner_write;
      ramaddr  = owner_data ? daddr[owner_core] : iaddr[owner_core];
      ramstore = owner_data ? dstore[owner_core] : '0;
      if (ack) begin
        if (owner_data) begin
          dwait[owner_core] = 1'b0;
          if (!owner_write) dload[owner_core] = ramload;
        end else begin
          iwait[owner_core] = 1'b0;
          iload[owner_core] = ramload;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      rr          <= '0;
      owner_core  <= '0;
      owner_data  <= 1'b0;
      owner_write <= 1'b0;
      wdog        <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_core  <= win_core;
            owner_data  <= win_data;
            owner_write <= win_write;
            wdog        <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (wdog != WDOG_MAX) wdog <= wdog + WW'(1);
          // ACCESS outranks a simultaneous drop or watchdog expiry.
          if (ack) begin
            state <= DONE;
          end else if (!own_req) begin
            state <= DONE;
          end else if (wdog == WDOG_LAST) begin
            timeout <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          rr    <= (owner_core == CORE_LAST) ? '0 : owner_core + CW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  localparam int CPUS    = 2;
  localparam int TIMEOUT = 8;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic                  CLK = 1'b0;
  logic                  nRST = 1'b0;
  logic [CPUS-1:0]       iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]       iwait, dwait;
  logic [CPUS-1:0][31:0] iload, dload;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic                  ramREN, ramWEN, timeout;
  logic [1:0]            ramstate;

  ram_bus_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // transaction-level reference state for the random phase
  bit          i_pend[CPUS], d_pend[CPUS], d_wr[CPUS], d_both[CPUS];
  logic [31:0] i_adr[CPUS], d_adr[CPUS], d_dat[CPUS];
  bit          act, act_data, act_write, ack_m, picked;
  logic        act_core, rr_m, sc;
  int          act_delay, next_pick, cyc;
  logic [CPUS-1:0]       exp_iwait, exp_dwait;
  logic [CPUS-1:0][31:0] exp_iload, exp_dload;
  logic [31:0] seen[4];
  int          n_seen;

  initial begin
    clear_inputs();

    // ---- 1: reset values, then reset in the middle of a grant
    nRST = 1'b0;
    tick();
    settle();
    check("rst_ren", 32'(ramREN), 32'h0);
    check("rst_wen", 32'(ramWEN), 32'h0);
    check("rst_addr", ramaddr, 32'h0);
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_timeout", 32'(timeout), 32'h0);
    tick();
    nRST = 1'b1;
    dREN = 2'b01; daddr[0] = 32'h100; ramstate = BUSY;
    settle();
    check("t1_idle_ren", 32'(ramREN), 32'h0);
    tick();
    settle();
    check("t1_grant_ren", 32'(ramREN), 32'h1);
    nRST = 1'b0;
    tick();
    settle();
    check("t1_after_rst_ren", 32'(ramREN), 32'h0);
    check("t1_after_rst_iwait", 32'(iwait), 32'h3);
    check("t1_after_rst_dwait", 32'(dwait), 32'h3);
    check("t1_after_rst_timeout", 32'(timeout), 32'h0);
    nRST = 1'b1;
    tick();
    settle();
    check("t1_regrant_ren", 32'(ramREN), 32'h1);

    // ---- 2: data read acked two cycles after the strobe
    do_reset();
    dREN = 2'b01; daddr[0] = 32'h100;
    settle();
    check("t2_idle_ren", 32'(ramREN), 32'h0);
    tick();
    ramstate = BUSY;
    settle();
    check("t2_ren", 32'(ramREN), 32'h1);
    check("t2_addr", ramaddr, 32'h100);
    check("t2_dwait_busy", 32'(dwait), 32'h3);
    tick();
    settle();
    check("t2_dwait_busy2", 32'(dwait), 32'h3);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    check("t2_dwait_ack", 32'(dwait), 32'h2);
    check("t2_dload0", dload[0], 32'hDEADBEEF);
    check("t2_dload1", dload[1], 32'h0);
    check("t2_iwait", 32'(iwait), 32'h3);
    tick();
    dREN = 2'b00; ramstate = FREE;
    settle();
    check("t2_done_dwait", 32'(dwait), 32'h3);
    check("t2_done_dload0", dload[0], 32'h0);
    check("t2_done_ren", 32'(ramREN), 32'h0);

    // ---- 3: data write beats instruction read of the same core
    do_reset();
    iREN = 2'b01; iaddr[0] = 32'h200;
    dWEN = 2'b01; daddr[0] = 32'h40; dstore[0] = 32'h5;
    tick();
    ramstate = ACCESS;
    settle();
    check("t3_wen", 32'(ramWEN), 32'h1);
    check("t3_ren", 32'(ramREN), 32'h0);
    check("t3_addr", ramaddr, 32'h40);
    check("t3_store", ramstore, 32'h5);
    check("t3_dwait", 32'(dwait), 32'h2);
    check("t3_iwait", 32'(iwait), 32'h3);
    tick();
    dWEN = 2'b00; ramstate = FREE;
    settle();
    check("t3_done_wen", 32'(ramWEN), 32'h0);
    tick();
    settle();
    check("t3_idle_ren", 32'(ramREN), 32'h0);
    tick();
    ramstate = ACCESS; ramload = 32'h1234;
    settle();
    check("t3_i_ren", 32'(ramREN), 32'h1);
    check("t3_i_addr", ramaddr, 32'h200);
    check("t3_i_iwait", 32'(iwait), 32'h2);
    check("t3_i_iload", iload[0], 32'h1234);
    tick();
    iREN = 2'b00; ramstate = FREE;

    // ---- 4: both cores hold dREN; grants alternate 0,1,0,1
    do_reset();
    dREN = 2'b11; daddr[0] = 32'h1000; daddr[1] = 32'h2000; ramstate = ACCESS;
    n_seen = 0;
    for (int n = 0; n < 12; n++) begin
      settle();
      if (ramREN && n_seen < 4) begin
        seen[n_seen] = ramaddr;
        n_seen++;
      end
      tick();
    end
    check("t4_count", 32'(n_seen), 32'h4);
    check("t4_g0", seen[0], 32'h1000);
    check("t4_g1", seen[1], 32'h2000);
    check("t4_g2", seen[2], 32'h1000);
    check("t4_g3", seen[3], 32'h2000);

    // ---- 5: watchdog abort with RAM stuck BUSY, then a normal grant
    do_reset();
    iREN = 2'b10; iaddr[1] = 32'h300; ramstate = BUSY;
    settle();
    check("t5_idle_ren", 32'(ramREN), 32'h0);
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      settle();
      check("t5_strobe", 32'(ramREN), 32'h1);
      check("t5_iwait", 32'(iwait), 32'h3);
      check("t5_timeout_low", 32'(timeout), 32'h0);
      tick();
    end
    settle();
    check("t5_done_ren", 32'(ramREN), 32'h0);
    check("t5_timeout", 32'(timeout), 32'h1);
    check("t5_done_iwait", 32'(iwait), 32'h3);
    tick();
    settle();
    check("t5_idle2_ren", 32'(ramREN), 32'h0);
    tick();
    ramstate = ACCESS; ramload = 32'h77;
    settle();
    check("t5_regrant_ren", 32'(ramREN), 32'h1);
    check("t5_regrant_addr", ramaddr, 32'h300);
    check("t5_regrant_iwait", 32'(iwait), 32'h1);
    check("t5_regrant_iload", iload[1], 32'h77);
    check("t5_timeout_sticky", 32'(timeout), 32'h1);
    tick();
    iREN = 2'b00; ramstate = FREE;

    // ---- 6: drop coinciding with ACCESS still acks; earlier drop does not
    do_reset();
    dREN = 2'b01; daddr[0] = 32'h500;
    tick();
    ramstate = BUSY;
    settle();
    check("t6_ren", 32'(ramREN), 32'h1);
    tick();
    dREN = 2'b00; ramstate = ACCESS; ramload = 32'hCAFE;
    settle();
    check("t6_drop_ack_dwait", 32'(dwait), 32'h2);
    check("t6_drop_ack_dload", dload[0], 32'hCAFE);
    tick();
    ramstate = FREE;
    settle();
    check("t6_done_ren", 32'(ramREN), 32'h0);
    tick();
    dREN = 2'b01;
    tick();
    ramstate = BUSY;
    settle();
    check("t6_b_ren", 32'(ramREN), 32'h1);
    tick();
    dREN = 2'b00;
    settle();
    check("t6_b_drop_dwait", 32'(dwait), 32'h3);
    tick();
    ramstate = ACCESS;
    settle();
    check("t6_b_noack_dwait", 32'(dwait), 32'h3);
    check("t6_b_done_ren", 32'(ramREN), 32'h0);
    tick();
    settle();
    check("t6_b_idle_ren", 32'(ramREN), 32'h0);
    check("t6_b_idle_dwait", 32'(dwait), 32'h3);

    // ---- random phase: caches hold requests until acked, RAM stalls 0..4 cycles
    do_reset();
    rr_m = 1'b0; next_pick = 0; act = 1'b0; cyc = 0;
    act_core = 1'b0; act_data = 1'b0; act_write = 1'b0; act_delay = 0;
    for (int c = 0; c < CPUS; c++) begin
      i_pend[c] = 1'b0; d_pend[c] = 1'b0; d_wr[c] = 1'b0; d_both[c] = 1'b0;
      i_adr[c] = '0; d_adr[c] = '0; d_dat[c] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!i_pend[c] && $urandom_range(0, 3) == 0) begin
          i_pend[c] = 1'b1;
          i_adr[c]  = $urandom;
        end
        if (!d_pend[c] && $urandom_range(0, 3) == 0) begin
          d_pend[c] = 1'b1;
          d_wr[c]   = ($urandom_range(0, 1) == 1);
          d_both[c] = ($urandom_range(0, 3) == 0);
          d_adr[c]  = $urandom;
          d_dat[c]  = $urandom;
        end
        iREN[c]   = i_pend[c];
        iaddr[c]  = i_adr[c];
        dREN[c]   = d_pend[c] && (!d_wr[c] || d_both[c]);
        dWEN[c]   = d_pend[c] && d_wr[c];
        daddr[c]  = d_adr[c];
        dstore[c] = d_dat[c];
      end
      if (act) ramstate = (act_delay > 0) ? (($urandom_range(0, 1) == 1) ? ERROR : BUSY) : ACCESS;
      else     ramstate = 2'($urandom_range(0, 3));
      ramload = $urandom;
      settle();

      ack_m     = act && (ramstate == ACCESS);
      exp_iwait = '1; exp_dwait = '1; exp_iload = '0; exp_dload = '0;
      if (ack_m) begin
        if (act_data) begin
          exp_dwait[act_core] = 1'b0;
          if (!act_write) exp_dload[act_core] = ramload;
        end else begin
          exp_iwait[act_core] = 1'b0;
          exp_iload[act_core] = ramload;
        end
      end
      check("rnd_ren", 32'(ramREN), 32'(act && !act_write));
      check("rnd_wen", 32'(ramWEN), 32'(act && act_write));
      if (act) check("rnd_addr", ramaddr, act_data ? d_adr[act_core] : i_adr[act_core]);
      if (act && act_write) check("rnd_store", ramstore, d_dat[act_core]);
      check("rnd_iwait", 32'(iwait), 32'(exp_iwait));
      check("rnd_dwait", 32'(dwait), 32'(exp_dwait));
      check("rnd_iload0", iload[0], exp_iload[0]);
      check("rnd_iload1", iload[1], exp_iload[1]);
      check("rnd_dload0", dload[0], exp_dload[0]);
      check("rnd_dload1", dload[1], exp_dload[1]);
      check("rnd_timeout", 32'(timeout), 32'h0);

      // Completion frees the bus two cycles later; a pick starts strobes next cycle.
      if (act) begin
        if (ack_m) begin
          if (act_data) d_pend[act_core] = 1'b0;
          else          i_pend[act_core] = 1'b0;
          act       = 1'b0;
          rr_m      = act_core + 1'b1;   // two cores: wraps 1 -> 0
          next_pick = cyc + 2;
        end else begin
          act_delay--;
        end
      end else if (cyc >= next_pick) begin
        picked = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
          sc = rr_m + 1'(k);
          if (!picked && (d_pend[sc] || i_pend[sc])) begin
            picked    = 1'b1;
            act_core  = sc;
            act_data  = d_pend[sc];
            act_write = d_pend[sc] && d_wr[sc];
          end
        end
        if (picked) begin
          act       = 1'b1;
          act_delay = $urandom_range(0, 4);
        end
      end
      cyc++;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
